hazard_control_unit: RTL

Pipeline hazard controller for the 5-stage CPU core; it sequences the IF/ID/EX pipeline registers around the EX-stage forwarding datapath. It:
- detects load-use hazards that forwarding cannot resolve;
- issues control-transfer flushes;
- tracks the multi-cycle multiply/divide unit (MDU) with a counter FSM, stalling HI/LO consumers until the result is ready.

It also keeps a wrap-around stall-cycle counter for performance analysis.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_control_unit_mdu_sequencer.sv | 84 ++++++++
 rtl/hazard_control_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The MDU sequencer is only built when HAZARD_MDU_SEQ_EN is defined.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam logic MDU_OP_MULT = 1'b0;
    localparam logic MDU_OP_DIV  = 1'b1;

    // Wide enough for a reload value of DIV_CYCLES-1 with the default 32.
    localparam int CNT_W = 6;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_control_unit_mdu_sequencer.sv
// Multi-cycle multiply/divide occupancy tracker.
// Present only when HAZARD_MDU_SEQ_EN is defined; otherwise the top ties
// the MDU status outputs low and the MDU is treated as single-cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no MDU operation outstanding
// BUSY  | operation occupying the unit, cnt counts remaining cycles-1
// DONE  | HI/LO valid this cycle; a new start may reload immediately
`ifdef HAZARD_MDU_SEQ_EN
module mdu_sequencer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic op,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] load_val;

    assign load_val = (op == MDU_OP_DIV) ? DIV_LOAD : MULT_LOAD;

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter update; a start seen in BUSY cannot happen.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = load_val;
                end
            end
            BUSY: begin
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - 1'b1;
            end
            DONE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = load_val;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use and HI/LO stalls, control-transfer
// flushes, and a wrap-around stall-cycle counter.
// Define HAZARD_MDU_SEQ_EN to build the multi-cycle MDU sequencer.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  RegWriteAddr_EX,
    input  logic        BranchTaken_ID,
    input  logic        Jump_ID,
    input  logic        MDUStart_EX,
    input  logic        MDUOp_EX,
    input  logic        MDUUse_ID,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MDUBusy,
    output logic        MDUDone,
    output logic [31:0] StallCount
);

    logic        lu;
    logic        md;
    logic        stall;
    logic [31:0] stall_cnt;

    // Load-use: a load in EX feeding ID cannot be forwarded in time; r0 never hazards.
    always_comb begin
        lu = MemRead_EX && (RegWriteAddr_EX != ZERO_REG) &&
             ((RegWriteAddr_EX == rs_ID) || (RegWriteAddr_EX == rt_ID));
    end

`ifdef HAZARD_MDU_SEQ_EN
    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (MDUStart_EX),
        .op      (MDUOp_EX),
        .busy    (MDUBusy),
        .done    (MDUDone)
    );

    // HI/LO consumers wait while the unit is busy or being started this cycle.
    always_comb begin
        md = MDUUse_ID && (MDUBusy || MDUStart_EX);
    end
`else
    logic unused_mdu;
    assign unused_mdu = ^{MDUStart_EX, MDUOp_EX, MDUUse_ID};
    assign MDUBusy    = 1'b0;
    assign MDUDone    = 1'b0;

    // Single-cycle MDU never stalls.
    always_comb begin
        md = 1'b0;
    end
`endif

    // Stall freezes PC and IF/ID and bubbles ID/EX; it wins over a flush so the
    // branch is re-evaluated once the stall clears.
    always_comb begin
        stall     = lu || md;
        PCWrite   = !stall;
        IFIDWrite = !stall;
        IDEXFlush = stall;
        IFIDFlush = !stall && (BranchTaken_ID || Jump_ID);
    end

    // Stall-cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end

    assign StallCount = stall_cnt;

endmodule
